inference_sequencer: RTL

- Control FSM that drives the stress-detector inference datapath: conv 3x3 → ReLU → FC pair → argmax.
- On `start`, it generates image-buffer and weight-ROM addresses plus `valid_pixel` for every KxK window of an IMG_H x IMG_W frame.
- It counts the per-window `prediction_valid` pulses from the datapath and majority-votes `stress_prediction` into one frame-level class.
- It sits between the host/frame buffer and the inference top level; a timeout guards against lost predictions.

---
 rtl/inference_pkg.sv | 35 +++
 rtl/window_addr_gen.sv | 104 ++++++++++
 rtl/inference_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/inference_pkg.sv
// -----------------------------------------------------------------------------
// inference_pkg
// Shared types and constants for the stress-detector inference sequencer.
//   state_t      : sequencer FSM states
//   DEF_*        : default frame geometry and derived window/beat counts
//   win_count()  : number of KxK windows in an img_w x img_h frame
// -----------------------------------------------------------------------------
package inference_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_IMG_W   = 8;
  localparam int DEF_IMG_H   = 8;
  localparam int DEF_K       = 3;
  localparam int DEF_TIMEOUT = 64;

  localparam int OUT_W  = DEF_IMG_W - DEF_K + 1;
  localparam int OUT_H  = DEF_IMG_H - DEF_K + 1;
  localparam int N_WIN  = OUT_W * OUT_H;
  localparam int N_BEAT = N_WIN * DEF_K * DEF_K;

  localparam int PIX_AW_DEF = $clog2(DEF_IMG_W * DEF_IMG_H);
  localparam int WGT_AW_DEF = $clog2(DEF_K * DEF_K);
  localparam int VOTE_W_DEF = $clog2(N_WIN + 1);

  function automatic int win_count(input int img_w, input int img_h, input int k);
    return (img_w - k + 1) * (img_h - k + 1);
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// -----------------------------------------------------------------------------
// window_addr_gen
// Walks every KxK window of an IMG_H x IMG_W frame, one tap per enabled cycle.
// Counter order, fastest first: kx, ky, col, row.
// Ports:
//   clk, rst     : clock, async active-high reset
//   clr          : return all counters to the first tap of the frame
//   en           : emit one beat this cycle and advance the counters
//   pix_addr     : registered image-buffer address (row+ky)*IMG_W + (col+kx)
//   wgt_addr     : registered weight-ROM address ky*K + kx
//   valid_pixel  : registered, high for the cycle after an enabled edge
//   win_last     : registered, last tap of a window, only when valid_pixel
//   frame_last   : counters currently sit on the final tap of the frame
// -----------------------------------------------------------------------------
module window_addr_gen
  import inference_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int PIX_AW = $clog2(IMG_W * IMG_H),
  parameter int WGT_AW = $clog2(K * K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [PIX_AW-1:0] pix_addr,
  output logic [WGT_AW-1:0] wgt_addr,
  output logic              valid_pixel,
  output logic              win_last,
  output logic              frame_last
);

  localparam int OW    = IMG_W - K + 1;
  localparam int OH    = IMG_H - K + 1;
  localparam int KC_W  = $clog2(K + 1);
  localparam int COL_W = $clog2(OW + 1);
  localparam int ROW_W = $clog2(OH + 1);

  logic [KC_W-1:0]  kx, ky;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic kx_last, ky_last, col_last, row_last;
  logic [PIX_AW-1:0] pix_next;
  logic [WGT_AW-1:0] wgt_next;

  assign kx_last    = (kx  == KC_W'(K - 1));
  assign ky_last    = (ky  == KC_W'(K - 1));
  assign col_last   = (col == COL_W'(OW - 1));
  assign row_last   = (row == ROW_W'(OH - 1));
  assign frame_last = kx_last && ky_last && col_last && row_last;

  assign pix_next = PIX_AW'((32'(row) + 32'(ky)) * 32'(IMG_W) + 32'(col) + 32'(kx));
  assign wgt_next = WGT_AW'(32'(ky) * 32'(K) + 32'(kx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx          <= '0;
      ky          <= '0;
      col         <= '0;
      row         <= '0;
      pix_addr    <= '0;
      wgt_addr    <= '0;
      valid_pixel <= 1'b0;
      win_last    <= 1'b0;
    end else if (clr) begin
      kx          <= '0;
      ky          <= '0;
      col         <= '0;
      row         <= '0;
      valid_pixel <= 1'b0;
      win_last    <= 1'b0;
    end else begin
      valid_pixel <= en;
      win_last    <= en && kx_last && ky_last;
      if (en) begin
        // Addresses hold while en is low so a stalled beat resumes unchanged.
        pix_addr <= pix_next;
        wgt_addr <= wgt_next;
        // Wrapping after the final tap leaves the counters ready for the next frame.
        if (!kx_last) begin
          kx <= kx + 1'b1;
        end else begin
          kx <= '0;
          if (!ky_last) begin
            ky <= ky + 1'b1;
          end else begin
            ky <= '0;
            if (!col_last) begin
              col <= col + 1'b1;
            end else begin
              col <= '0;
              if (!row_last) row <= row + 1'b1;
              else           row <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
// Sequences one frame through the conv/ReLU/FC/argmax datapath: streams the
// pixel/weight addresses of every KxK window, then collects the per-window
// predictions and majority-votes them into a frame class.
// Ports:
//   clk, rst           : clock, async active-high reset (aborts a frame, no done)
//   start              : begin a frame; honoured only in IDLE or DONE
//   stall              : freezes streaming while high
//   prediction_valid   : per-window result strobe, stress_prediction its class
//   pix_addr, wgt_addr : registered memory addresses for the current beat
//   valid_pixel        : beat valid; win_last marks its last tap of a window
//   busy               : high in STREAM and DRAIN
//   done               : one-cycle pulse at frame completion
//   result_class       : 1 when vote_count*2 > number of windows
//   vote_count         : windows classified as 1
//   timeout_err        : frame ended because predictions stopped arriving
//   state_dbg          : current FSM state
// Strobe semantics: valid_pixel and prediction_valid are single-cycle
// qualifiers with no ready; a high cycle is one transfer. Stall is the only
// back-pressure and it suppresses valid_pixel rather than holding it high.
// -----------------------------------------------------------------------------
module inference_sequencer
  import inference_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int K       = DEF_K,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int PIX_AW  = $clog2(IMG_W * IMG_H),
  parameter int WGT_AW  = $clog2(K * K),
  parameter int VOTE_W  = $clog2((IMG_W - K + 1) * (IMG_H - K + 1) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              prediction_valid,
  input  logic              stress_prediction,
  output logic [PIX_AW-1:0] pix_addr,
  output logic [WGT_AW-1:0] wgt_addr,
  output logic              valid_pixel,
  output logic              win_last,
  output logic              busy,
  output logic              done,
  output logic              result_class,
  output logic [VOTE_W-1:0] vote_count,
  output logic              timeout_err,
  output state_t            state_dbg
);

  localparam int NW     = win_count(IMG_W, IMG_H, K);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_t state, next_state;

  logic [VOTE_W-1:0] pred_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              stream_en;
  logic              frame_last;
  logic              accept_start;
  logic              all_preds;
  logic              pred_take;
  logic              timeout_hit;

  assign stream_en    = (state == STREAM) && !stall;
  assign accept_start = start && ((state == IDLE) || (state == DONE));
  assign all_preds    = (pred_cnt == VOTE_W'(NW));
  assign pred_take    = prediction_valid && !all_preds &&
                        ((state == STREAM) || (state == DRAIN));
  // A prediction arriving on the threshold cycle wins over the timeout.
  assign timeout_hit  = (state == DRAIN) && !all_preds && !prediction_valid &&
                        (idle_cnt == IDLE_W'(TIMEOUT));

  window_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .PIX_AW(PIX_AW),
    .WGT_AW(WGT_AW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept_start),
    .en         (stream_en),
    .pix_addr   (pix_addr),
    .wgt_addr   (wgt_addr),
    .valid_pixel(valid_pixel),
    .win_last   (win_last),
    .frame_last (frame_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = STREAM;
      STREAM:  if (stream_en && frame_last) next_state = DRAIN;
      DRAIN:   if (all_preds || timeout_hit) next_state = DONE;
      DONE:    next_state = start ? STREAM : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_cnt     <= '0;
      vote_count   <= '0;
      idle_cnt     <= '0;
      timeout_err  <= 1'b0;
      result_class <= 1'b0;
    end else if (accept_start) begin
      pred_cnt     <= '0;
      vote_count   <= '0;
      idle_cnt     <= '0;
      timeout_err  <= 1'b0;
      result_class <= 1'b0;
    end else begin
      if (pred_take) begin
        pred_cnt <= pred_cnt + 1'b1;
        if (stress_prediction) vote_count <= vote_count + 1'b1;
      end
      // Outside DRAIN the counter sits at zero, so DRAIN always starts fresh.
      if (state == DRAIN && !prediction_valid) idle_cnt <= idle_cnt + 1'b1;
      else                                     idle_cnt <= '0;
      if (state == DRAIN && next_state == DONE) begin
        result_class <= (32'(vote_count) << 1) > 32'(NW);
        timeout_err  <= timeout_hit;
      end
    end
  end

  assign busy      = (state == STREAM) || (state == DRAIN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
